// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: drives a req/ack data-memory bus from the ALU effective address,
// handling byte-lane alignment, byte enables, load extension and stall/fault signalling.
//
// state  | meaning
// S_IDLE | waiting for memRead/memWrite; stall follows the request combinationally
// S_REQ  | bus_req held high until bus_ack or wait-counter timeout
// S_DONE | one retire cycle; fault/faultCode valid, stall low
module mem_access_unit #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memRead,
   input  logic          memWrite,
   input  logic [1:0]    size,
   input  logic          signExt,
   input  logic [N-1:0]  address,
   input  logic [63:0]   writeData,
   output logic [63:0]   readData,
   output logic          stall,
   output logic          fault,
   output logic [1:0]    faultCode,
   output logic          bus_req,
   output logic          bus_we,
   output logic [N-1:0]  bus_addr,
   output logic [63:0]   bus_wdata,
   output logic [7:0]    bus_be,
   input  logic          bus_ack,
   input  logic [63:0]   bus_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CODE_CONFLICT = 2'b11;

   logic [1:0]  state;
   logic [7:0]  wait_cnt;
   logic [2:0]  off;
   logic [1:0]  size_q;
   logic        sext_q;

   logic        req_any;
   logic        misaligned;
   logic [1:0]  code_nxt;
   logic [7:0]  be_nxt;
   logic [63:0] wdata_nxt;
   logic [63:0] shifted;
   logic [63:0] ld_val;

   always_comb begin
      req_any    = memRead | memWrite;
      misaligned = 1'b0;
      be_nxt     = 8'hFF;
      case (size)
         2'b00: begin
            misaligned = 1'b0;
            be_nxt     = 8'h01 << address[2:0];
         end
         2'b01: begin
            misaligned = address[0];
            be_nxt     = 8'h03 << address[2:0];
         end
         2'b10: begin
            misaligned = |address[1:0];
            be_nxt     = 8'h0F << address[2:0];
         end
         default: begin
            misaligned = |address[2:0];
            be_nxt     = 8'hFF;
         end
      endcase
      if (memRead && memWrite)
         code_nxt = CODE_CONFLICT;
      else if (misaligned)
         code_nxt = CODE_MISALIGN;
      else
         code_nxt = CODE_NONE;
      wdata_nxt = writeData << {address[2:0], 3'b000};
   end

   // Load lane extraction uses the offset/size captured at request time, not the live inputs.
   always_comb begin
      shifted = bus_rdata >> {off, 3'b000};
      case (size_q)
         2'b00:   ld_val = sext_q ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
         2'b01:   ld_val = sext_q ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
         2'b10:   ld_val = sext_q ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
         default: ld_val = shifted;
      endcase
   end

   always_comb begin
      case (state)
         S_IDLE:  stall = req_any;
         S_REQ:   stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         wait_cnt  <= 8'd0;
         off       <= 3'd0;
         size_q    <= 2'd0;
         sext_q    <= 1'b0;
         readData  <= 64'd0;
         fault     <= 1'b0;
         faultCode <= CODE_NONE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= 64'd0;
         bus_be    <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               fault     <= 1'b0;
               faultCode <= CODE_NONE;
               if (req_any) begin
                  if (code_nxt != CODE_NONE) begin
                     state     <= S_DONE;
                     fault     <= 1'b1;
                     faultCode <= code_nxt;
                  end else begin
                     state     <= S_REQ;
                     wait_cnt  <= 8'd0;
                     bus_req   <= 1'b1;
                     bus_we    <= memWrite;
                     bus_addr  <= {address[N-1:3], 3'b000};
                     bus_be    <= be_nxt;
                     bus_wdata <= wdata_nxt;
                     off       <= address[2:0];
                     size_q    <= size;
                     sext_q    <= signExt;
                  end
               end
            end
            S_REQ: begin
               // An ack on the final wait cycle takes priority over the timeout.
               if (bus_ack) begin
                  state   <= S_DONE;
                  bus_req <= 1'b0;
                  if (!bus_we)
                     readData <= ld_val;
               end else if (wait_cnt == WAIT_LAST) begin
                  state     <= S_DONE;
                  bus_req   <= 1'b0;
                  fault     <= 1'b1;
                  faultCode <= CODE_TIMEOUT;
                  if (!bus_we)
                     readData <= 64'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               wait_cnt  <= 8'd0;
               fault     <= 1'b0;
               faultCode <= CODE_NONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-access expectations come from an arithmetic model of
// lane/extension rules, checked every cycle at the falling edge, plus literal pins.
module tb_mem_access_unit;

   localparam int N  = 64;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          memRead, memWrite, signExt;
   logic [1:0]    size;
   logic [N-1:0]  address;
   logic [63:0]   writeData;
   logic [63:0]   readData;
   logic          stall, fault;
   logic [1:0]    faultCode;
   logic          bus_req, bus_we;
   logic [N-1:0]  bus_addr;
   logic [63:0]   bus_wdata;
   logic [7:0]    bus_be;
   logic          bus_ack;
   logic [63:0]   bus_rdata;

   mem_access_unit #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .size(size),
      .signExt(signExt), .address(address), .writeData(writeData), .readData(readData),
      .stall(stall), .fault(fault), .faultCode(faultCode), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic          chk_en = 1'b0;
   logic          exp_stall, exp_req, exp_fault, exp_we;
   logic [1:0]    exp_code;
   logic [63:0]   exp_rd, exp_addr, exp_wdata;
   logic [7:0]    exp_be;
   int            stall_cnt, req_cnt;
   logic [7:0]    cap_be;
   logic [63:0]   cap_addr, cap_wdata;
   logic          cap_we;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ld_model(input logic [63:0] rdata, input logic [2:0] o,
                                            input logic [1:0] sz, input logic sx);
      int          bits;
      logic [63:0] v, mask;
      bits = 8 << sz;
      v    = rdata >> (8 * int'(o));
      if (bits == 64) return v;
      mask = (64'd1 << bits) - 64'd1;
      v    = v & mask;
      if (sx && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] be_model(input logic [1:0] sz, input logic [2:0] o);
      logic [15:0] t;
      t = ((16'd1 << (1 << sz)) - 16'd1) << o;
      return t[7:0];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", 64'(stall), 64'(exp_stall));
         chk("bus_req", 64'(bus_req), 64'(exp_req));
         chk("fault", 64'(fault), 64'(exp_fault));
         chk("faultCode", 64'(faultCode), 64'(exp_code));
         chk("readData", readData, exp_rd);
         if (exp_req) begin
            chk("bus_we", 64'(bus_we), 64'(exp_we));
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_be", 64'(bus_be), 64'(exp_be));
            chk("bus_wdata", bus_wdata, exp_wdata);
         end
         if (stall) stall_cnt++;
         if (bus_req) begin
            req_cnt++;
            cap_be    = bus_be;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
            cap_we    = bus_we;
         end
      end
   end

   // ack_at: REQ cycle (1-based) carrying bus_ack; 0 means the bus never answers.
   task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] rdat, input int ack_at);
      logic [1:0] code;
      logic       tmo;
      if (rd && wr)                        code = 2'b11;
      else if ((addr % (64'd1 << sz)) != 0) code = 2'b01;
      else                                 code = 2'b00;
      stall_cnt = 0;
      req_cnt   = 0;
      memRead   = rd;
      memWrite  = wr;
      size      = sz;
      signExt   = sx;
      address   = addr;
      writeData = wd;
      exp_stall = 1'b1;
      exp_req   = 1'b0;
      exp_fault = 1'b0;
      exp_code  = 2'b00;
      @(posedge clk); #1;
      if (code == 2'b00) begin
         exp_req   = 1'b1;
         exp_we    = wr;
         exp_addr  = {addr[63:3], 3'b000};
         exp_be    = be_model(sz, addr[2:0]);
         exp_wdata = wd << (8 * int'(addr[2:0]));
         bus_rdata = rdat;
         for (int k = 1; k <= TO; k++) begin
            bus_ack = (k == ack_at);
            @(posedge clk); #1;
            if (k == ack_at || k == TO) break;
         end
         bus_ack = 1'b0;
         tmo = (ack_at < 1 || ack_at > TO);
         if (tmo) code = 2'b10;
         if (rd) exp_rd = tmo ? 64'd0 : ld_model(rdat, addr[2:0], sz, sx);
      end
      memRead   = 1'b0;
      memWrite  = 1'b0;
      exp_stall = 1'b0;
      exp_req   = 1'b0;
      exp_fault = (code != 2'b00);
      exp_code  = code;
      @(posedge clk); #1;
      exp_fault = 1'b0;
      exp_code  = 2'b00;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; size = 2'b00; signExt = 1'b0;
      address = '0; writeData = '0; bus_ack = 1'b0; bus_rdata = '0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_code = 2'b00; exp_rd = '0;
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
      stall_cnt = 0; req_cnt = 0; cap_be = '0; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst readData", readData, 64'd0);
      chk("rst bus_req", 64'(bus_req), 64'd0);
      chk("rst bus_we", 64'(bus_we), 64'd0);
      chk("rst bus_addr", bus_addr, 64'd0);
      chk("rst bus_wdata", bus_wdata, 64'd0);
      chk("rst bus_be", 64'(bus_be), 64'd0);
      chk("rst fault", {62'd0, faultCode} | 64'(fault), 64'd0);
      chk("rst stall", 64'(stall), 64'd0);
      chk_en = 1'b1;
      @(posedge clk); #1;

      do_access(1, 0, 2'b11, 0, 64'h100, 64'd0, 64'h0123456789ABCDEF, 1);
      chk("dword rd", readData, 64'h0123456789ABCDEF);
      chk("dword be", 64'(cap_be), 64'hFF);
      chk("dword addr", cap_addr, 64'h100);
      chk("dword stall cycles", 64'(stall_cnt), 64'd2);

      do_access(1, 0, 2'b00, 1, 64'h10B, 64'd0, 64'h0000_0000_8000_0000, 1);
      chk("sbyte rd", readData, 64'hFFFF_FFFF_FFFF_FF80);
      chk("sbyte be", 64'(cap_be), 64'h08);
      do_access(1, 0, 2'b00, 0, 64'h10B, 64'd0, 64'h0000_0000_8000_0000, 1);
      chk("ubyte rd", readData, 64'h80);

      do_access(0, 1, 2'b01, 0, 64'h206, 64'hBEEF, 64'hDEAD_DEAD_DEAD_DEAD, 3);
      chk("hstore we", 64'(cap_we), 64'd1);
      chk("hstore be", 64'(cap_be), 64'hC0);
      chk("hstore wdata", cap_wdata, 64'hBEEF_0000_0000_0000);
      chk("hstore stall cycles", 64'(stall_cnt), 64'd4);
      chk("hstore rd kept", readData, 64'h80);

      do_access(1, 0, 2'b10, 0, 64'h102, 64'd0, 64'd0, 1);
      chk("misalign no req", 64'(req_cnt), 64'd0);
      do_access(1, 1, 2'b11, 0, 64'h100, 64'd0, 64'd0, 1);
      chk("conflict no req", 64'(req_cnt), 64'd0);
      do_access(1, 0, 2'b01, 0, 64'h101, 64'd0, 64'd0, 1);
      do_access(0, 1, 2'b11, 0, 64'h104, 64'd0, 64'd0, 1);

      do_access(1, 0, 2'b10, 1, 64'h104, 64'd0, 64'h8765_4321_0000_0000, 2);
      chk("sword rd", readData, 64'hFFFF_FFFF_8765_4321);
      do_access(1, 0, 2'b01, 0, 64'h10E, 64'd0, 64'hF00D_0000_0000_0000, 1);
      chk("uhalf rd", readData, 64'hF00D);
      do_access(0, 1, 2'b00, 0, 64'h107, 64'h12, 64'd0, 2);
      chk("bstore be", 64'(cap_be), 64'h80);
      chk("bstore wdata", cap_wdata, 64'h1200_0000_0000_0000);

      do_access(1, 0, 2'b11, 0, 64'h308, 64'd0, 64'h1122_3344_5566_7788, TO);
      chk("ack16 rd", readData, 64'h1122_3344_5566_7788);
      chk("ack16 req cycles", 64'(req_cnt), 64'd16);
      do_access(1, 0, 2'b11, 0, 64'h300, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      chk("timeout req cycles", 64'(req_cnt), 64'd16);
      chk("timeout rd", readData, 64'd0);

      // Reset on the 2nd REQ cycle, then a stray ack the cycle after.
      stall_cnt = 0; req_cnt = 0;
      memRead = 1'b1; size = 2'b11; signExt = 1'b0; address = 64'h400;
      exp_stall = 1'b1; exp_req = 1'b0;
      @(posedge clk); #1;
      exp_req = 1'b1; exp_we = 1'b0; exp_addr = 64'h400; exp_be = 8'hFF; exp_wdata = 64'd0;
      writeData = 64'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; memRead = 1'b0; bus_ack = 1'b1; bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b0; exp_code = 2'b00; exp_rd = 64'd0;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst-mid req cycles", 64'(req_cnt), 64'd2);
      chk("rst-mid rd", readData, 64'd0);
      chk("rst-mid bus_req", 64'(bus_req), 64'd0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
